// File: rtl/set_query_master_if.sv
// Bundle of request, engine and result signals between the SET host master and its neighbours.
// The master modport is the set_query_master view; slave is the producer/engine/consumer side.
interface set_query_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_central;
  logic [11:0] req_radius;
  logic [1:0]  req_mode;

  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;

  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_candidate;
  logic [1:0]  res_tag;
  logic        res_err;

  modport master (
    input  req_valid, req_central, req_radius, req_mode,
    input  set_busy, set_valid, set_candidate,
    input  res_ready,
    output req_ready,
    output set_en, set_central, set_radius, set_mode,
    output res_valid, res_candidate, res_tag, res_err
  );

  modport slave (
    output req_valid, req_central, req_radius, req_mode,
    output set_busy, set_valid, set_candidate,
    output res_ready,
    input  req_ready,
    input  set_en, set_central, set_radius, set_mode,
    input  res_valid, res_candidate, res_tag, res_err
  );
endinterface

// File: rtl/set_query_master.sv
// Host-side initiator for the SET lattice-counting engine: queues queries, issues them one at a
// time with stable operands, and returns tagged in-order results, converting engine hangs to errors.
module set_query_master #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  set_query_master_if.master bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int WD_W    = $clog2(TIMEOUT + 1);
  localparam int ENTRY_W = 38;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

  state_t               state;
  logic [ENTRY_W-1:0]   fifo_mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push;
  logic                 pop;
  logic [ENTRY_W-1:0]   head;
  logic [1:0]           issue_tag;
  logic [WD_W-1:0]      watchdog;

  assign bus.req_ready = (count < CNT_W'(DEPTH));
  assign push          = bus.req_valid & bus.req_ready;
  assign pop           = (state == IDLE) && (count != '0);
  assign head          = fifo_mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.req_central, bus.req_radius, bus.req_mode};
  end

  // Operands stay put from issue until the next pop, since the engine latches them a cycle after en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      issue_tag         <= '0;
      watchdog          <= '0;
      bus.set_en        <= 1'b0;
      bus.set_central   <= '0;
      bus.set_radius    <= '0;
      bus.set_mode      <= '0;
      bus.res_valid     <= 1'b0;
      bus.res_candidate <= '0;
      bus.res_tag       <= '0;
      bus.res_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {bus.set_central, bus.set_radius, bus.set_mode} <= head;
            bus.set_en <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          bus.set_en <= 1'b0;
          watchdog   <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (bus.set_valid) begin
            bus.res_candidate <= bus.set_candidate;
            bus.res_err       <= 1'b0;
            bus.res_tag       <= issue_tag;
            bus.res_valid     <= 1'b1;
            issue_tag         <= issue_tag + 1'b1;
            state             <= RESULT;
          end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
            bus.res_candidate <= '0;
            bus.res_err       <= 1'b1;
            bus.res_tag       <= issue_tag;
            bus.res_valid     <= 1'b1;
            issue_tag         <= issue_tag + 1'b1;
            state             <= RESULT;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_query_master.sv
// Directed bench for set_query_master with a behavioural SET engine that counts lattice points
// on an 8x8 grid; expected counts are hand-computed constants.
module tb_set_query_master;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;
  localparam int ENG_LAT = 40;

  logic clk;
  logic rst;
  set_query_master_if bus ();

  set_query_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int en_pulses = 0;

  logic       eng_run;
  logic       eng_valid;
  logic [7:0] eng_cand;
  logic       eng_hang;
  int         eng_cnt;
  logic [23:0] eng_c;
  logic [11:0] eng_r;
  logic [1:0]  eng_m;
  logic       spur_valid;
  logic [7:0] spur_cand;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.set_valid     = eng_valid | spur_valid;
  assign bus.set_candidate = eng_valid ? eng_cand : spur_cand;
  assign bus.set_busy      = eng_run;

  function automatic bit in_circle(int x, int y, int xc, int yc, int r);
    return ((x - xc) * (x - xc) + (y - yc) * (y - yc)) <= r * r;
  endfunction

  function automatic logic [7:0] lattice_count(logic [23:0] c, logic [11:0] r, logic [1:0] m);
    int n = 0;
    bit a, b, d, hit;
    for (int x = 1; x <= 8; x++) begin
      for (int y = 1; y <= 8; y++) begin
        a = in_circle(x, y, c[23:20], c[19:16], r[11:8]);
        b = in_circle(x, y, c[15:12], c[11:8],  r[7:4]);
        d = in_circle(x, y, c[7:4],   c[3:0],   r[3:0]);
        case (m)
          2'd0:    hit = a;
          2'd1:    hit = a & b;
          2'd2:    hit = a ^ b;
          default: hit = ((int'(a) + int'(b) + int'(d)) == 2);
        endcase
        if (hit) n++;
      end
    end
    return 8'(n);
  endfunction

  // Engine model: latches operands the cycle after en, answers ENG_LAT cycles later unless hung.
  always @(posedge clk) begin
    eng_valid <= 1'b0;
    if (!rst) begin
      eng_run <= 1'b0;
      eng_cnt <= 0;
    end else if (bus.set_en === 1'b1) begin
      eng_run <= 1'b1;
      eng_cnt <= 0;
    end else if (eng_run) begin
      if (eng_cnt == 0) begin
        eng_c <= bus.set_central;
        eng_r <= bus.set_radius;
        eng_m <= bus.set_mode;
      end
      if (eng_cnt == ENG_LAT) begin
        eng_run <= 1'b0;
        if (!eng_hang) begin
          eng_valid <= 1'b1;
          eng_cand  <= lattice_count(eng_c, eng_r, eng_m);
        end
      end
      eng_cnt <= eng_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (bus.set_en === 1'b1) en_pulses <= en_pulses + 1;
  end

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(logic [23:0] central, logic [11:0] radius, logic [1:0] mode);
    int k = 0;
    @(negedge clk);
    bus.req_central = central;
    bus.req_radius  = radius;
    bus.req_mode    = mode;
    bus.req_valid   = 1'b1;
    while (bus.req_ready !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) checkOutput("push_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic waitResult(output logic [7:0] cand, output logic [1:0] tag, output logic err);
    int k = 0;
    while (bus.res_valid !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) checkOutput("result_timeout", 32'(bus.res_valid), 32'd1);
    cand = bus.res_candidate;
    tag  = bus.res_tag;
    err  = bus.res_err;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] cand;
  logic [1:0] tag;
  logic       err;
  int         en_base;
  int         k;
  logic [7:0] exp_c [5] = '{8'd5, 8'd13, 8'd29, 8'd1, 8'd5};
  logic [1:0] exp_t [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_central = '0;
    bus.req_radius = '0;
    bus.req_mode = '0;
    bus.res_ready = 1'b1;
    eng_hang = 1'b0;
    spur_valid = 1'b0;
    spur_cand = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_set_en", 32'(bus.set_en), 32'd0);
    checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("rst_set_central", 32'(bus.set_central), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single mode-0 query: en timing, operand hold, result.
    $display("[TB] single query");
    en_base = en_pulses;
    applyStimulus(24'h440000, 12'h200, 2'd0);
    @(negedge clk);
    checkOutput("en_not_early", 32'(bus.set_en), 32'd0);
    @(negedge clk);
    checkOutput("en_timing", 32'(bus.set_en), 32'd1);
    checkOutput("issue_central", 32'(bus.set_central), 32'h440000);
    repeat (10) @(negedge clk);
    checkOutput("hold_central", 32'(bus.set_central), 32'h440000);
    checkOutput("hold_radius", 32'(bus.set_radius), 32'h200);
    checkOutput("en_single_cycle", 32'(bus.set_en), 32'd0);
    waitResult(cand, tag, err);
    checkOutput("q0_cand", 32'(cand), 32'd13);
    checkOutput("q0_tag", 32'(tag), 32'd0);
    checkOutput("q0_err", 32'(err), 32'd0);
    checkOutput("q0_en_pulses", 32'(en_pulses - en_base), 32'd1);

    $display("[TB] modes 1 and 2");
    applyStimulus(24'h444400, 12'h220, 2'd1);
    waitResult(cand, tag, err);
    checkOutput("mode1_cand", 32'(cand), 32'd13);
    checkOutput("mode1_tag", 32'(tag), 32'd1);
    applyStimulus(24'h444400, 12'h220, 2'd2);
    waitResult(cand, tag, err);
    checkOutput("mode2_cand", 32'(cand), 32'd0);
    checkOutput("mode2_tag", 32'(tag), 32'd2);

    $display("[TB] back-pressure");
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    bus.res_ready = 1'b0;
    applyStimulus(24'h440000, 12'h000, 2'd0);
    applyStimulus(24'h440000, 12'h100, 2'd0);
    applyStimulus(24'h440000, 12'h200, 2'd0);
    applyStimulus(24'h440000, 12'h300, 2'd0);
    applyStimulus(24'h440000, 12'h000, 2'd0);
    checkOutput("full_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.req_central = 24'h440000;
    bus.req_radius  = 12'h100;
    bus.req_mode    = 2'd0;
    bus.req_valid   = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("stall_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("stall_valid", 32'(bus.res_valid), 32'd1);
    checkOutput("stall_tag", 32'(bus.res_tag), 32'd0);
    checkOutput("stall_cand", 32'(bus.res_candidate), 32'd1);
    bus.res_ready = 1'b1;
    waitResult(cand, tag, err);
    checkOutput("bp0_cand", 32'(cand), 32'd1);
    checkOutput("bp0_tag", 32'(tag), 32'd0);
    k = 0;
    while (bus.req_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) checkOutput("bp_push6_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      waitResult(cand, tag, err);
      checkOutput($sformatf("bp%0d_cand", i + 1), 32'(cand), 32'(exp_c[i]));
      checkOutput($sformatf("bp%0d_tag", i + 1), 32'(tag), 32'(exp_t[i]));
    end

    $display("[TB] watchdog");
    eng_hang = 1'b1;
    applyStimulus(24'h440000, 12'h200, 2'd0);
    k = 0;
    while (bus.set_en !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    k = 0;
    while (bus.res_valid !== 1'b1 && k < TIMEOUT + 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("wd_latency", 32'(k), 32'(TIMEOUT));
    waitResult(cand, tag, err);
    checkOutput("wd_err", 32'(err), 32'd1);
    checkOutput("wd_cand", 32'(cand), 32'd0);
    checkOutput("wd_tag", 32'(tag), 32'd2);
    eng_hang = 1'b0;
    applyStimulus(24'h440000, 12'h100, 2'd0);
    waitResult(cand, tag, err);
    checkOutput("post_wd_cand", 32'(cand), 32'd5);
    checkOutput("post_wd_err", 32'(err), 32'd0);
    checkOutput("post_wd_tag", 32'(tag), 32'd3);

    $display("[TB] spurious valid");
    en_base = en_pulses;
    @(negedge clk);
    spur_cand = 8'h77;
    spur_valid = 1'b1;
    @(negedge clk) spur_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("spur_idle_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("spur_idle_en", 32'(en_pulses - en_base), 32'd0);
    bus.res_ready = 1'b0;
    applyStimulus(24'h440000, 12'h200, 2'd0);
    waitResult(cand, tag, err);
    @(negedge clk) spur_valid = 1'b1;
    @(negedge clk) spur_valid = 1'b0;
    @(negedge clk);
    checkOutput("spur_res_valid", 32'(bus.res_valid), 32'd1);
    checkOutput("spur_res_cand", 32'(bus.res_candidate), 32'd13);
    checkOutput("spur_res_tag", 32'(bus.res_tag), 32'd0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    checkOutput("spur_consumed", 32'(bus.res_valid), 32'd0);
    spur_valid = 1'b1;
    @(negedge clk) spur_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("spur_idle2_valid", 32'(bus.res_valid), 32'd0);
    applyStimulus(24'h440000, 12'h000, 2'd0);
    waitResult(cand, tag, err);
    checkOutput("spur_next_cand", 32'(cand), 32'd1);
    checkOutput("spur_next_tag", 32'(tag), 32'd1);

    $display("[TB] reset mid-wait");
    for (int i = 0; i < 4; i++) applyStimulus(24'h444400, 12'h220, 2'd1);
    repeat (15) @(negedge clk);
    checkOutput("pre_rst_mode", 32'(bus.set_mode), 32'd1);
    rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    checkOutput("mid_rst_set_en", 32'(bus.set_en), 32'd0);
    checkOutput("mid_rst_central", 32'(bus.set_central), 32'd0);
    checkOutput("mid_rst_radius", 32'(bus.set_radius), 32'd0);
    checkOutput("mid_rst_mode", 32'(bus.set_mode), 32'd0);
    checkOutput("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("mid_rst_res_cand", 32'(bus.res_candidate), 32'd0);
    checkOutput("mid_rst_res_tag", 32'(bus.res_tag), 32'd0);
    checkOutput("mid_rst_res_err", 32'(bus.res_err), 32'd0);
    checkOutput("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    en_base = en_pulses;
    repeat (10) @(negedge clk);
    checkOutput("mid_rst_fifo_empty", 32'(en_pulses - en_base), 32'd0);
    applyStimulus(24'h440000, 12'h300, 2'd0);
    waitResult(cand, tag, err);
    checkOutput("post_rst_cand", 32'(cand), 32'd29);
    checkOutput("post_rst_tag", 32'(tag), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] global timeout");
  end

endmodule
